// File: rtl/uart_msg_tx.sv
// rtl/uart_msg_tx.sv - FIFO-buffered 8N1 UART transmitter for fault-report bytes
module uart_msg_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic       clk_50M,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    output logic       full,
    output logic       empty,
    output logic       tx,
    output logic       tx_busy,
    output logic       overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   CNT_FULL  = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [BW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          push;
    logic          pop;
    logic          baud_done;

    assign full      = (count == CNT_FULL);
    assign empty     = (count == '0);
    assign baud_done = (baud_cnt == BAUD_LAST);
    assign push      = wr_en && !full;
    // Pops happen only when the FSM loads a new frame: from IDLE, or on the last stop-bit cycle.
    assign pop       = !empty && ((state == IDLE) || ((state == STOP) && baud_done));
    assign tx_busy   = (state != IDLE);

    always_ff @(posedge clk_50M) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (wr_en && full) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            tx       <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (pop) begin
                        shift    <= mem[rd_ptr];
                        baud_cnt <= '0;
                        tx       <= 1'b0;
                        state    <= START;
                    end
                end
                START: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        tx       <= shift[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shift   <= shift >> 1;
                            tx      <= shift[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        // Chain straight into the next start bit so bursts leave no idle gap.
                        if (pop) begin
                            shift <= mem[rd_ptr];
                            tx    <= 1'b0;
                            state <= START;
                        end else begin
                            tx    <= 1'b1;
                            state <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_msg_tx.sv
// tb/tb_uart_msg_tx.sv - directed/random bench for uart_msg_tx with a line decoder and byte-order model
module tb_uart_msg_tx;

    localparam int CPB   = 20;
    localparam int DEPTH = 16;
    localparam int FRAME = 10 * CPB;

    logic       clk_50M = 1'b0;
    logic       rst     = 1'b1;
    logic       wr_en   = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       full, empty, tx, tx_busy, overflow;

    int checks = 0;
    int errors = 0;

    int         cyc = 0;
    int         busy_cnt = 0;
    int         glitch = 0;
    int         ferr = 0;
    int         pos = 0;
    bit         in_frame = 1'b0;
    logic       cur = 1'b1;
    logic [7:0] shreg = 8'h00;
    logic [7:0] rx_q[$];
    int         start_q[$];

    logic [7:0] exp_q[$];
    int         rx_done = 0;
    logic [7:0] msg [10] = '{8'h46, 8'h49, 8'h4D, 8'h2D, 8'h43, 8'h53, 8'h55, 8'h31, 8'h2D, 8'h23};

    uart_msg_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk_50M (clk_50M),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .full    (full),
        .empty   (empty),
        .tx      (tx),
        .tx_busy (tx_busy),
        .overflow(overflow)
    );

    always #5 clk_50M = ~clk_50M;

    always @(posedge clk_50M) cyc++;

    // Line decoder: one sample per cycle, every bit must hold its level for CPB cycles.
    always @(negedge clk_50M) begin
        if (tx_busy) busy_cnt++;
        if (rst) begin
            in_frame = 1'b0;
        end else begin
            if (!in_frame && tx === 1'b0) begin
                in_frame = 1'b1;
                pos = 0;
                start_q.push_back(cyc);
            end
            if (in_frame) begin
                if (pos % CPB == 0) begin
                    cur = tx;
                    if (pos / CPB >= 1 && pos / CPB <= 8) shreg[pos / CPB - 1] = cur;
                    if (pos / CPB == 9 && cur !== 1'b1) ferr++;
                end else if (tx !== cur) begin
                    glitch++;
                end
                if (pos == FRAME - 1) begin
                    rx_q.push_back(shreg);
                    in_frame = 1'b0;
                end else begin
                    pos++;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        @(posedge clk_50M);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while ((tx_busy || !empty || in_frame) && n < budget) begin
            @(negedge clk_50M);
            n++;
        end
        chk(tag, 32'(n < budget), 32'd1);
        repeat (2) @(posedge clk_50M);
        #1;
    endtask

    task automatic check_rx(input string tag);
        chk({tag, "_count"}, 32'(rx_q.size()), 32'(exp_q.size()));
        for (int i = rx_done; i < exp_q.size() && i < rx_q.size(); i++)
            chk($sformatf("%s_byte%0d", tag, i), 32'(rx_q[i]), 32'(exp_q[i]));
        rx_done = exp_q.size();
    endtask

    initial begin
        int b0, s0, occ;
        bit dropped;
        logic [7:0] v;

        repeat (3) @(posedge clk_50M);
        #1;
        chk("rst_tx", tx, 1);
        chk("rst_busy", tx_busy, 0);
        chk("rst_full", full, 0);
        chk("rst_empty", empty, 1);
        chk("rst_ovf", overflow, 0);
        rst = 1'b0;
        @(posedge clk_50M);
        #1;
        chk("post_rst_tx", tx, 1);

        // Single byte: latency and frame length
        b0 = busy_cnt;
        push(8'h46);
        exp_q.push_back(8'h46);
        chk("single_empty_e0", empty, 0);
        chk("single_tx_e0", tx, 1);
        @(posedge clk_50M);
        #1;
        chk("single_tx_e1", tx, 0);
        chk("single_busy_e1", tx_busy, 1);
        chk("single_empty_e1", empty, 1);
        wait_idle("single_timeout", 3 * FRAME);
        check_rx("single");
        chk("single_busy_cycles", 32'(busy_cnt - b0), 32'(FRAME));
        chk("single_end_busy", tx_busy, 0);
        chk("single_end_empty", empty, 1);

        // Burst of the fault report on consecutive cycles
        b0 = busy_cnt;
        s0 = start_q.size();
        for (int i = 0; i < 10; i++) begin
            wr_en = 1'b1;
            wr_data = msg[i];
            exp_q.push_back(msg[i]);
            @(posedge clk_50M);
            #1;
        end
        wr_en = 1'b0;
        wait_idle("burst_timeout", 12 * FRAME);
        check_rx("burst");
        chk("burst_busy_cycles", 32'(busy_cnt - b0), 32'(10 * FRAME));
        chk("burst_span", 32'(start_q[s0 + 9] - start_q[s0]), 32'(9 * FRAME));
        chk("burst_ovf", overflow, 0);

        // Overflow: 17 writes while a frame holds the line
        v = 8'($urandom);
        push(v);
        exp_q.push_back(v);
        repeat (3) @(posedge clk_50M);
        #1;
        chk("ovf_busy", tx_busy, 1);
        occ = 0;
        dropped = 1'b0;
        for (int i = 0; i < 17; i++) begin
            wr_en = 1'b1;
            wr_data = 8'(i);
            @(posedge clk_50M);
            #1;
            if (occ < DEPTH) begin
                occ++;
                exp_q.push_back(8'(i));
            end else begin
                dropped = 1'b1;
            end
            chk($sformatf("ovf_full_w%0d", i), full, 32'(occ == DEPTH));
            chk($sformatf("ovf_flag_w%0d", i), overflow, 32'(dropped));
        end
        wr_en = 1'b0;
        wait_idle("ovf_timeout", 20 * FRAME);
        check_rx("ovf");
        chk("ovf_sticky", overflow, 1);

        // Reset during data bit 3 (0x52 has bit 3 low, so tx must visibly rise)
        push(8'h52);
        repeat (1 + 4 * CPB + CPB / 2) @(posedge clk_50M);
        #3;
        chk("mid_busy", tx_busy, 1);
        chk("mid_tx_bit3", tx, 0);
        rst = 1'b1;
        #1;
        chk("mid_rst_tx", tx, 1);
        chk("mid_rst_empty", empty, 1);
        chk("mid_rst_full", full, 0);
        chk("mid_rst_ovf", overflow, 0);
        chk("mid_rst_busy", tx_busy, 0);
        repeat (2) @(posedge clk_50M);
        #1;
        rst = 1'b0;
        repeat (3 * FRAME) @(posedge clk_50M);
        #1;
        chk("mid_quiet_count", 32'(rx_q.size()), 32'(exp_q.size()));
        chk("mid_quiet_tx", tx, 1);
        push(8'h23);
        exp_q.push_back(8'h23);
        wait_idle("mid_timeout", 3 * FRAME);
        check_rx("mid_after");

        // Push on the final stop cycle while one byte is queued
        s0 = start_q.size();
        v = 8'($urandom);
        push(v);
        exp_q.push_back(v);
        v = 8'($urandom);
        push(v);
        exp_q.push_back(v);
        repeat (FRAME - 1) @(posedge clk_50M);
        #1;
        v = 8'($urandom);
        push(v);
        exp_q.push_back(v);
        chk("pp_empty", empty, 0);
        chk("pp_full", full, 0);
        chk("pp_tx_start", tx, 0);
        chk("pp_busy", tx_busy, 1);
        wait_idle("pp_timeout", 5 * FRAME);
        check_rx("pp");
        chk("pp_gap1", 32'(start_q[s0 + 1] - start_q[s0]), 32'(FRAME));
        chk("pp_gap2", 32'(start_q[s0 + 2] - start_q[s0 + 1]), 32'(FRAME));

        // Pointer wrap: 40 random bytes in groups of 8 with random gaps
        for (int g = 0; g < 5; g++) begin
            for (int k = 0; k < 8; k++) begin
                v = 8'($urandom);
                push(v);
                exp_q.push_back(v);
                chk($sformatf("wrap_full_%0d", g * 8 + k), full, 0);
                repeat ($urandom_range(0, 3)) @(posedge clk_50M);
                #1;
            end
            wait_idle($sformatf("wrap_timeout_%0d", g), 10 * FRAME);
        end
        check_rx("wrap");
        chk("wrap_ovf", overflow, 0);

        chk("line_glitches", 32'(glitch), 32'd0);
        chk("stop_bit_errors", 32'(ferr), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
